jt900h_useq: RTL
================

// Module: jt900h_useq
// PURPOSE
//  Parametrised micro-sequencer for the JT900H control unit: generates the ucode address.
//  Sources: segment-local increment, opcode dispatch, absolute jump, and JSR/RET through an
//  N-deep return stack (nested subroutines), plus a counted micro-loop.
//  Sits between the instruction decoder (dispatch address, conditions) and the ucode ROM.
// PARAMETERS
//  UA_W    14      micro-address width
//  LO_W    4       low field that increments and wraps inside a 2^LO_W-entry segment
//  DEPTH   4       return-stack entries (>=1); SW = clog2(DEPTH+1)
//  CNT_W   8       loop counter width
//  RST_UA  0       uaddr after reset and after a RET on an empty stack
// PORTS
//  clk       in   1      clock
//  rst       in   1      synchronous active-high reset
//  cen       in   1      clock enable; all state holds when low
//  still     in   1      stall (divider or memory busy); all state holds when high
//  ni        in   1      next instruction: dispatch to ni_ua
//  ni_ua     in   UA_W   dispatch address built by the decoder
//  jmp       in   1      absolute jump to jmp_ua
//  jmp_ua    in   UA_W   jump target
//  jsr       in   1      subroutine call to jsr_ua
//  jsr_skip  in   1      condition false: suppress the jsr of this cycle
//  jsr_ua    in   UA_W   subroutine target
//  ret       in   1      return: pop the stack
//  loop_set  in   1      mark the loop start and load the counter
//  loop_cnt  in   CNT_W  number of extra iterations loaded by loop_set
//  loop_chk  in   1      loop end test
//  uaddr     out  UA_W   current micro-address
//  stk_lvl   out  SW     number of valid stack entries
//  stk_ovf   out  1      sticky: push attempted while full
//  stk_unf   out  1      sticky: pop attempted while empty
//  loop_z    out  1      loop counter == 0 (combinational)
// BEHAVIOUR
//  - Reset is synchronous and active-high and wins over cen. It sets:
//    uaddr=RST_UA, stk_lvl=0, stk_ovf=0, stk_unf=0, counter=0, loop start=0.
//    Stack contents are don't-care.
//  - Advance cycle: clk edge with cen=1 and still=0. Everything else holds state.
//  - Priority in an advance cycle (only the highest active action applies):
//    ret > jsr (when jsr_skip=0) > jmp > ni > loop_chk taken > increment.
//  - Increment: uaddr[LO_W-1:0] += 1 modulo 2^LO_W. Upper bits are unchanged.
//  - ret with stk_lvl>0: uaddr <= top entry; stk_lvl -= 1.
//  - ret with stk_lvl==0: uaddr <= RST_UA; stk_unf <= 1; stk_lvl stays 0.
//  - jsr:
//    - Pushes uaddr with its low field incremented (same wrap rule); stk_lvl += 1.
//    - uaddr <= jsr_ua.
//    - When full, the push is dropped, stk_ovf <= 1, and the jump still occurs.
//  - jsr with jsr_skip=1 is ignored: lower-priority actions apply as if jsr were 0.
//  - ret and jsr in the same cycle: ret only; jsr is discarded.
//  - loop_set:
//    - Loads counter <= loop_cnt and loop start <= uaddr[LO_W-1:0].
//    - Executes in addition to whichever uaddr action wins.
//  - loop_chk with counter!=0 is taken when no higher action is active:
//    - counter -= 1.
//    - uaddr <= {uaddr[UA_W-1:LO_W], loop start}.
//  - loop_chk with counter==0 falls through to increment.
//  - loop_set and loop_chk in the same cycle: loop_set loads, no jump is taken.
//  - Overlapping loops are not supported: a new loop_set overwrites the loop state.
//  - Latency: uaddr changes one advance cycle after the request is sampled.
//    No combinational path from inputs to uaddr.
//  - stk_ovf and stk_unf clear only on rst.
// TESTING
//  - Wrap: reset, RST_UA=0x12E; two advance cycles -> uaddr 0x12F, then 0x120.
//  - Nested calls: DEPTH=4; jsr at 0x010->0x200, 0x200->0x300, 0x300->0x400.
//    Then three rets -> uaddr 0x301, 0x201, 0x011; stk_lvl 3,2,1,0; no flags set.
//  - Overflow: five jsr with DEPTH=4 -> stk_lvl=4, stk_ovf=1, uaddr = fifth target.
//    Then five rets -> 4 valid pops, the fifth gives RST_UA and stk_unf=1.
//  - Loop: loop_set with loop_cnt=3 at 0x052; loop_chk at 0x054 ->
//    0x052 three times, then 0x055; loop_z=1 after the third pass.
//  - Stall and cen: still=1 or cen=0 during jsr -> uaddr and stk_lvl unchanged;
//    the jsr executes on the first advance cycle.
//  - Priority and reset: ret+jsr+ni together -> pop only. jsr_skip=1 with ni -> dispatch.
//    rst mid-loop with cen=0 -> all outputs at reset values next clk.

Source files
------------

// File: rtl/jt900h_useq.sv
// Micro-sequencer for the JT900H control unit: computes the next ucode address from
// segment increment, dispatch, jump, JSR/RET through a return stack, and a counted micro-loop.
module jt900h_useq #(
  parameter int UA_W  = 14,
  parameter int LO_W  = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8,
  parameter logic [UA_W-1:0] RST_UA = '0,
  localparam int SW = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             still,
  input  logic             ni,
  input  logic [UA_W-1:0]  ni_ua,
  input  logic             jmp,
  input  logic [UA_W-1:0]  jmp_ua,
  input  logic             jsr,
  input  logic             jsr_skip,
  input  logic [UA_W-1:0]  jsr_ua,
  input  logic             ret,
  input  logic             loop_set,
  input  logic [CNT_W-1:0] loop_cnt,
  input  logic             loop_chk,
  output logic [UA_W-1:0]  uaddr,
  output logic [SW-1:0]    stk_lvl,
  output logic             stk_ovf,
  output logic             stk_unf,
  output logic             loop_z
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SW-1:0] FULL = SW'(DEPTH);

  logic [UA_W-1:0]  stk [DEPTH];
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [LO_W-1:0]  lstart, lstart_nx;
  logic [UA_W-1:0]  uaddr_nx, inc_ua, top_ua;
  logic [SW-1:0]    lvl_nx;
  logic             ovf_nx, unf_nx, push;
  logic [IW-1:0]    wr_idx, rd_idx;
  logic             adv;

  assign adv    = cen & ~still;
  assign inc_ua = {uaddr[UA_W-1:LO_W], uaddr[LO_W-1:0] + LO_W'(1)};
  assign wr_idx = IW'(stk_lvl);
  assign rd_idx = IW'(stk_lvl - SW'(1));
  assign top_ua = stk[rd_idx];
  assign loop_z = (cnt == '0);

  always_comb begin
    uaddr_nx  = uaddr;
    lvl_nx    = stk_lvl;
    ovf_nx    = stk_ovf;
    unf_nx    = stk_unf;
    cnt_nx    = cnt;
    lstart_nx = lstart;
    push      = 1'b0;
    if (adv) begin
      if (ret) begin
        if (stk_lvl != '0) begin
          uaddr_nx = top_ua;
          lvl_nx   = stk_lvl - SW'(1);
        end else begin
          uaddr_nx = RST_UA;
          unf_nx   = 1'b1;
        end
      end else if (jsr && !jsr_skip) begin
        uaddr_nx = jsr_ua;
        if (stk_lvl == FULL) begin
          ovf_nx = 1'b1;
        end else begin
          push   = 1'b1;
          lvl_nx = stk_lvl + SW'(1);
        end
      end else if (jmp) begin
        uaddr_nx = jmp_ua;
      end else if (ni) begin
        uaddr_nx = ni_ua;
      end else if (loop_chk && !loop_set && !loop_z) begin
        // loop_set in the same cycle cancels the back-branch
        cnt_nx   = cnt - CNT_W'(1);
        uaddr_nx = {uaddr[UA_W-1:LO_W], lstart};
      end else begin
        uaddr_nx = inc_ua;
      end
      if (loop_set) begin
        cnt_nx    = loop_cnt;
        lstart_nx = uaddr[LO_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      uaddr   <= RST_UA;
      stk_lvl <= '0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
      cnt     <= '0;
      lstart  <= '0;
    end else begin
      uaddr   <= uaddr_nx;
      stk_lvl <= lvl_nx;
      stk_ovf <= ovf_nx;
      stk_unf <= unf_nx;
      cnt     <= cnt_nx;
      lstart  <= lstart_nx;
    end
  end

  // Stack contents need no reset; stk_lvl alone marks what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push) stk[wr_idx] <= inc_ua;
  end

endmodule
